// File: rtl/eth_cmd_parser.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// eth_cmd_parser
//
// Receive-side framing stage that sits directly behind the RGMII receiver. It
// takes the assembled byte stream and does four jobs:
//   * strips the preamble and SFD,
//   * accepts only frames addressed to MAC_ADDR or to broadcast that carry
//     ETHERTYPE,
//   * checks the length and the FCS,
//   * emits one 32-bit control command per good frame.
// The first four payload bytes of a good frame become the command. Saturating
// good/bad frame counters are kept for the status display.
//
// Optional feature (compile-time macro ETH_CMD_SRC_MAC_EN):
//   When defined, the source MAC (header bytes 6..11) is captured and is
//   presented on cmd_src_mac together with each command. The transmit path
//   uses it to address replies. When undefined, the port does not exist and
//   the source address is not stored.
//
// Ports:
//   rxclk        in   1  receive clock, one byte per cycle, rising edge
//   rstn         in   1  synchronous active-low reset
//   rx_dv        in   1  byte valid / frame envelope
//   rx_er        in   1  receive error, only meaningful while rx_dv=1
//   rx_d         in   8  received byte
//   cmd_valid    out  1  one-cycle pulse, new command on cmd_data
//   cmd_data     out 32  payload bytes 0..3, byte 0 in [31:24]; held
//   frm_ok_cnt   out 16  frames that produced a command, saturating
//   frm_err_cnt  out 16  errored frames, saturating
//   busy         out  1  a frame is being parsed (not IDLE / WAIT_IDLE)
//   cmd_src_mac  out 48  (ETH_CMD_SRC_MAC_EN only) source MAC of command
// -----------------------------------------------------------------------------
module eth_cmd_parser #(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic        rxclk,
    input  logic        rstn,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_d,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_err_cnt,
    output logic        busy
`ifdef ETH_CMD_SRC_MAC_EN
    ,
    output logic [47:0] cmd_src_mac
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_PREAMBLE  = 3'd2;
    localparam logic [2:0] ST_HDR       = 3'd3;
    localparam logic [2:0] ST_PAYLOAD   = 3'd4;
    localparam logic [2:0] ST_DROP_ERR  = 3'd5;

    localparam logic [7:0]  BYTE_PRE    = 8'h55;
    localparam logic [7:0]  BYTE_SFD    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    // The register value left behind after the FCS has also been run through
    // the CRC when the frame is intact.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT = 11'h7FF;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // One byte of reflected CRC-32. Bits are taken LSB first, as on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Destination byte expected at header position idx. Byte 0 is the MSB.
    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return MAC_ADDR[47:40];
            3'd1:    return MAC_ADDR[39:32];
            3'd2:    return MAC_ADDR[31:24];
            3'd3:    return MAC_ADDR[23:16];
            3'd4:    return MAC_ADDR[15:8];
            default: return MAC_ADDR[7:0];
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]  state_q,     state_d;
    logic [31:0] crc_q,       crc_d;
    logic [10:0] cnt_q,       cnt_d;        // bytes since SFD, saturating
    logic        err_q,       err_d;        // rx_er seen or frame too long
    logic        filt_q,      filt_d;       // drop_filt: not addressed to us
    logic        ne_mac_q,    ne_mac_d;     // dst differs from MAC_ADDR so far
    logic        ne_bc_q,     ne_bc_d;      // dst differs from broadcast so far
    logic [31:0] stage_q,     stage_d;      // payload bytes 0..3
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] cmd_data_q,  cmd_data_d;
    logic [15:0] ok_cnt_q,    ok_cnt_d;
    logic [15:0] err_cnt_q,   err_cnt_d;
`ifdef ETH_CMD_SRC_MAC_EN
    logic [47:0] src_q,       src_d;        // header bytes 6..11, in flight
    logic [47:0] cmd_src_q,   cmd_src_d;    // published with the command
`endif

    // Combinational helpers used by the next-state logic
    logic [10:0] cnt_inc;
    logic [31:0] crc_upd;
    logic        frame_good;
    logic [7:0]  et_ref;

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
    assign crc_upd = crc32_byte(crc_q, rx_d);
    // Header byte 12 is the EtherType MSB and byte 13 the LSB.
    assign et_ref  = cnt_q[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
    // Only the good condition is evaluated here. A frame that ends while
    // still in the header is rejected at the end-of-frame decision below.
    assign frame_good = !err_q && (cnt_q >= MIN_CNT) && (cnt_q <= MAX_CNT) &&
                        (crc_q == CRC_RESIDUE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d defaults to its _q, so no path through the case
        // leaves a signal unassigned. This keeps the block free of latches.
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        filt_d      = filt_q;
        ne_mac_d    = ne_mac_q;
        ne_bc_d     = ne_bc_q;
        stage_d     = stage_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;
`ifdef ETH_CMD_SRC_MAC_EN
        src_d       = src_q;
        cmd_src_d   = cmd_src_q;
`endif

        case (state_q)
            // After reset we may be in the middle of someone else's frame.
            // Stay here until the line goes quiet.
            ST_WAIT_IDLE: begin
                if (!rx_dv) state_d = ST_IDLE;
            end

            // IDLE and PREAMBLE react to the same bytes. The only difference
            // is which state rx_dv=0 leads to, and both go to IDLE, so one
            // branch serves both. An SFD with no preamble is accepted.
            ST_IDLE, ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rx_d == BYTE_SFD) begin
                    state_d  = ST_HDR;
                    crc_d    = CRC_INIT;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    filt_d   = 1'b0;
                    ne_mac_d = 1'b0;
                    ne_bc_d  = 1'b0;
                end else if (rx_d == BYTE_PRE) begin
                    state_d = ST_PREAMBLE;
                end else begin
                    state_d   = ST_DROP_ERR;
                    err_cnt_d = sat_inc16(err_cnt_q);
                end
            end

            ST_HDR, ST_PAYLOAD: begin
                if (rx_dv) begin
                    crc_d = crc_upd;
                    cnt_d = cnt_inc;
                    if (rx_er || (cnt_inc > MAX_CNT)) err_d = 1'b1;

                    if (state_q == ST_HDR) begin
                        if (cnt_q < 11'd6) begin
                            // The destination must match one whole address.
                            // A mix of MAC and FF bytes matches neither.
                            ne_mac_d = ne_mac_q | (rx_d != mac_byte(cnt_q[2:0]));
                            ne_bc_d  = ne_bc_q  | (rx_d != 8'hFF);
                            if (cnt_q == 11'd5) filt_d = filt_q | (ne_mac_d & ne_bc_d);
                        end else if (cnt_q >= 11'd12) begin
                            if (rx_d != et_ref) filt_d = 1'b1;
                        end
`ifdef ETH_CMD_SRC_MAC_EN
                        else begin
                            src_d = {src_q[39:0], rx_d};
                        end
`endif
                        if (cnt_q == 11'd13) state_d = ST_PAYLOAD;
                    end else if (cnt_q < 11'd18) begin
                        stage_d = {stage_q[23:0], rx_d};
                    end
                end else begin
                    // End of frame. The line may carry a new frame on the
                    // very next cycle, so go straight to IDLE.
                    state_d = ST_IDLE;
                    if (frame_good && (state_q == ST_PAYLOAD)) begin
                        if (!filt_q) begin
                            cmd_valid_d = 1'b1;
                            cmd_data_d  = stage_q;
                            ok_cnt_d    = sat_inc16(ok_cnt_q);
`ifdef ETH_CMD_SRC_MAC_EN
                            cmd_src_d   = src_q;
`endif
                        end
                    end else begin
                        err_cnt_d = sat_inc16(err_cnt_q);
                    end
                end
            end

            ST_DROP_ERR: begin
                if (!rx_dv) state_d = ST_IDLE;
            end

            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge rxclk) begin
        // NOTE: non-blocking assignments here. Every flop then samples the
        // pre-edge value of every other flop, whatever the statement order.
        if (!rstn) begin
            state_q     <= ST_WAIT_IDLE;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            filt_q      <= 1'b0;
            ne_mac_q    <= 1'b0;
            ne_bc_q     <= 1'b0;
            stage_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
`ifdef ETH_CMD_SRC_MAC_EN
            src_q       <= '0;
            cmd_src_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            filt_q      <= filt_d;
            ne_mac_q    <= ne_mac_d;
            ne_bc_q     <= ne_bc_d;
            stage_q     <= stage_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
`ifdef ETH_CMD_SRC_MAC_EN
            src_q       <= src_d;
            cmd_src_q   <= cmd_src_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = cmd_data_q;
    assign frm_ok_cnt  = ok_cnt_q;
    assign frm_err_cnt = err_cnt_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);
`ifdef ETH_CMD_SRC_MAC_EN
    assign cmd_src_mac = cmd_src_q;
`endif

endmodule
